// File: rtl/posi_md_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : posi_md_ram_arb
// Purpose  : Single-port RAM access arbiter with a built-in clear sequencer.
//            In IDLE, a write and a read requester share the RAM port. A lone
//            requester is granted at once. When both request, grants
//            round-robin, and the first conflict goes to the write side.
//            In CLR, every RAM entry is written with CLR_VAL (one per cycle)
//            and all requests are held off.
// Ports    : clk, rstn (async, active-low)
//            clr_start_i / clr_done_o / busy_o : clear control and status
//            wr_req_i, wr_adr_i, wr_dat_i, wr_ack_o : write requester
//            rd_req_i, rd_adr_i, rd_ack_o, rd_vld_o, rd_dat_o : read requester
//            ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o,
//            ram_rd_dat_i : RAM side (enables active-low, outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module posi_md_ram_arb #(
    parameter int unsigned ADR_WD  = 6,
    parameter int unsigned DAT_WD  = 6,
    parameter int unsigned CLR_VAL = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_start_i,
    output logic              clr_done_o,
    output logic              busy_o,
    input  logic              wr_req_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_vld_o,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i
);

    localparam logic [0:0]        c_ST_IDLE = 1'b0;
    localparam logic [0:0]        c_ST_CLR  = 1'b1;
    localparam logic [ADR_WD-1:0] c_CNT_MAX = {ADR_WD{1'b1}};
    localparam logic [DAT_WD-1:0] c_CLR_DAT = DAT_WD'(CLR_VAL);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADR_WD-1:0] r_cnt;
    logic              r_last_wr;     // 1: last conflict went to write
    logic              r_last_issue;  // final clear write is on the ram_* outputs
    logic              r_clr_done;
    logic              r_rd_p1;       // read enable is on the RAM port
    logic              r_rd_p2;       // RAM read data is valid on ram_rd_dat_i
    logic              r_rd_vld;
    logic [DAT_WD-1:0] r_rd_dat;
    logic [ADR_WD-1:0] r_ram_adr;
    logic [DAT_WD-1:0] r_ram_wr_dat;
    logic              r_ram_wr_ena;
    logic              r_ram_rd_ena;
    logic              w_busy;
    logic              w_conflict;
    logic              w_wr_ack;
    logic              w_rd_ack;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (clr_start_i)          w_state_nxt = c_ST_CLR;
            c_ST_CLR:  if (r_cnt == c_CNT_MAX)   w_state_nxt = c_ST_IDLE;
            default:                             w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- output / grant logic ----------------
    always_comb begin
        w_busy     = (r_state == c_ST_CLR);
        w_conflict = wr_req_i & rd_req_i;
        w_wr_ack   = 1'b0;
        w_rd_ack   = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_conflict) begin
                // The side that did not win the previous conflict wins now.
                w_wr_ack = ~r_last_wr;
                w_rd_ack = r_last_wr;
            end else begin
                w_wr_ack = wr_req_i;
                w_rd_ack = rd_req_i;
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_last_wr    <= 1'b0;
            r_last_issue <= 1'b0;
            r_clr_done   <= 1'b0;
            r_rd_p1      <= 1'b0;
            r_rd_p2      <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_dat     <= '0;
            r_ram_adr    <= '0;
            r_ram_wr_dat <= '0;
            r_ram_wr_ena <= 1'b1;
            r_ram_rd_ena <= 1'b1;
        end else begin
            if (r_state == c_ST_IDLE && clr_start_i) begin
                r_cnt <= '0;
            end else if (r_state == c_ST_CLR) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Only contested grants move the round-robin pointer.
            if (r_state == c_ST_IDLE && w_conflict) begin
                r_last_wr <= w_wr_ack;
            end

            r_last_issue <= (r_state == c_ST_CLR) && (r_cnt == c_CNT_MAX);
            r_clr_done   <= r_last_issue;

            r_ram_wr_ena <= 1'b1;
            r_ram_rd_ena <= 1'b1;
            if (r_state == c_ST_CLR) begin
                r_ram_wr_ena <= 1'b0;
                r_ram_adr    <= r_cnt;
                r_ram_wr_dat <= c_CLR_DAT;
            end else if (w_wr_ack) begin
                r_ram_wr_ena <= 1'b0;
                r_ram_adr    <= wr_adr_i;
                r_ram_wr_dat <= wr_dat_i;
            end else if (w_rd_ack) begin
                r_ram_rd_ena <= 1'b0;
                r_ram_adr    <= rd_adr_i;
            end

            // Read pipeline runs independently of the FSM so a clear that
            // starts right after a read grant still returns that read.
            r_rd_p1  <= w_rd_ack;
            r_rd_p2  <= r_rd_p1;
            r_rd_vld <= r_rd_p2;
            if (r_rd_p2) begin
                r_rd_dat <= ram_rd_dat_i;
            end
        end
    end

    assign busy_o       = w_busy;
    assign wr_ack_o     = w_wr_ack;
    assign rd_ack_o     = w_rd_ack;
    assign clr_done_o   = r_clr_done;
    assign rd_vld_o     = r_rd_vld;
    assign rd_dat_o     = r_rd_dat;
    assign ram_adr_o    = r_ram_adr;
    assign ram_wr_dat_o = r_ram_wr_dat;
    assign ram_wr_ena_o = r_ram_wr_ena;
    assign ram_rd_ena_o = r_ram_rd_ena;

endmodule
`default_nettype wire

// File: tb/tb_posi_md_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_posi_md_ram_arb
// Purpose  : Scoreboard bench for posi_md_ram_arb. A behavioural RAM sits on
//            the RAM port; a per-cycle reference model predicts grants, RAM
//            commands, clear timing and read returns from the intended rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posi_md_ram_arb;

    localparam int AW    = 6;
    localparam int DW    = 6;
    localparam int CV    = 'h15;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          clr_start_i = 1'b0;
    logic          clr_done_o, busy_o;
    logic          wr_req_i = 1'b0;
    logic [AW-1:0] wr_adr_i = '0;
    logic [DW-1:0] wr_dat_i = '0;
    logic          wr_ack_o;
    logic          rd_req_i = 1'b0;
    logic [AW-1:0] rd_adr_i = '0;
    logic          rd_ack_o, rd_vld_o;
    logic [DW-1:0] rd_dat_o;
    logic [AW-1:0] ram_adr_o;
    logic          ram_wr_ena_o, ram_rd_ena_o;
    logic [DW-1:0] ram_wr_dat_o;
    logic [DW-1:0] ram_rd_dat_i;

    posi_md_ram_arb #(.ADR_WD(AW), .DAT_WD(DW), .CLR_VAL(CV)) dut (
        .clk(clk), .rstn(rstn), .clr_start_i(clr_start_i),
        .clr_done_o(clr_done_o), .busy_o(busy_o),
        .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
        .wr_ack_o(wr_ack_o),
        .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o),
        .rd_vld_o(rd_vld_o), .rd_dat_o(rd_dat_o),
        .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o),
        .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o),
        .ram_rd_dat_i(ram_rd_dat_i)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM: read data appears the cycle after sampling.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_rd_ena_o) ram_rd_dat_i <= ram_mem[ram_adr_o];
        if (!ram_wr_ena_o) ram_mem[ram_adr_o] <= ram_wr_dat_o;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [DW-1:0] model_mem [DEPTH];
    bit            mon_en = 0;
    bit            m_busy = 0;
    int            m_cnt = 0;
    bit            m_last_wr = 0;
    bit            e_wr_ena = 1, e_rd_ena = 1;
    logic [AW-1:0] e_adr = '0;
    logic [DW-1:0] e_dat = '0;
    bit            e_done = 0, d1 = 0;
    bit            got_wr = 0, got_rd = 0;
    int            q_due[$];
    logic [DW-1:0] q_dat[$];

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_last_wr = 0;
        e_wr_ena = 1; e_rd_ena = 1; e_adr = '0; e_dat = '0;
        e_done = 0; d1 = 0; got_wr = 0; got_rd = 0;
        q_due.delete(); q_dat.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            bit busy0, ew, er;
            chk("ram_wr_ena", ram_wr_ena_o, e_wr_ena);
            chk("ram_rd_ena", ram_rd_ena_o, e_rd_ena);
            chk("ram_adr", ram_adr_o, e_adr);
            chk("ram_wr_dat", ram_wr_dat_o, e_dat);
            chk("busy", busy_o, m_busy);
            chk("clr_done", clr_done_o, e_done);
            e_done = d1; d1 = 0;

            if (rd_vld_o) begin
                if (q_due.size() == 0) chk("rd_vld_unexpected", rd_vld_o, 0);
                else begin
                    chk("rd_vld_time", cyc, q_due[0]);
                    chk("rd_dat", rd_dat_o, q_dat[0]);
                    void'(q_due.pop_front()); void'(q_dat.pop_front());
                end
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                chk("rd_vld_missing", rd_vld_o, 1);
                void'(q_due.pop_front()); void'(q_dat.pop_front());
            end

            busy0 = m_busy; ew = 0; er = 0;
            if (!m_busy) begin
                if (wr_req_i && rd_req_i) begin
                    ew = !m_last_wr; er = m_last_wr; m_last_wr = ew;
                end else begin
                    ew = wr_req_i; er = rd_req_i;
                end
            end
            chk("wr_ack", wr_ack_o, ew);
            chk("rd_ack", rd_ack_o, er);
            got_wr = ew; got_rd = er;

            if (m_busy) begin
                e_wr_ena = 0; e_rd_ena = 1; e_adr = m_cnt[AW-1:0]; e_dat = DW'(CV);
                model_mem[m_cnt] = DW'(CV);
                m_cnt++;
                if (m_cnt == DEPTH) begin m_busy = 0; d1 = 1; end
            end else if (ew) begin
                e_wr_ena = 0; e_rd_ena = 1; e_adr = wr_adr_i; e_dat = wr_dat_i;
                model_mem[wr_adr_i] = wr_dat_i;
            end else if (er) begin
                e_wr_ena = 1; e_rd_ena = 0; e_adr = rd_adr_i;
                q_due.push_back(cyc + 3); q_dat.push_back(model_mem[rd_adr_i]);
            end else begin
                e_wr_ena = 1; e_rd_ena = 1;
            end
            if (!busy0 && clr_start_i) begin m_busy = 1; m_cnt = 0; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        mon_en = 0; rstn = 1'b0;
        wr_req_i = 0; rd_req_i = 0; clr_start_i = 0;
        #1;
        chk("rst_ram_wr_ena", ram_wr_ena_o, 1);
        chk("rst_ram_rd_ena", ram_rd_ena_o, 1);
        chk("rst_ram_adr", ram_adr_o, 0);
        chk("rst_ram_wr_dat", ram_wr_dat_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);
        chk("rst_rd_vld", rd_vld_o, 0);
        chk("rst_clr_done", clr_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_ack", wr_ack_o, 0);
        chk("rst_rd_ack", rd_ack_o, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1; mon_en = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        tick(); clr_start_i = 1;
        tick(); clr_start_i = 0;
    endtask

    task automatic wait_wr();
        int k = 0;
        while (!got_wr && k < 200) begin tick(); k++; end
        chk("wr_ack_timeout", got_wr, 1);
    endtask

    task automatic wait_rd();
        int k = 0;
        while (!got_rd && k < 200) begin tick(); k++; end
        chk("rd_ack_timeout", got_rd, 1);
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            tick();
            clr_start_i = ($urandom_range(0, 299) == 0);
            if (!wr_req_i || got_wr) begin
                wr_req_i = ($urandom_range(0, 2) != 0);
                wr_adr_i = AW'($urandom); wr_dat_i = DW'($urandom);
            end
            if (!rd_req_i || got_rd) begin
                rd_req_i = ($urandom_range(0, 2) != 0);
                rd_adr_i = AW'($urandom);
            end
        end
        tick(); wr_req_i = 0; rd_req_i = 0; clr_start_i = 0;
        repeat (80) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1 do_reset();
        repeat (2) tick();

        // Clear with a write held throughout; write granted on first IDLE cycle.
        pulse_clear();
        wr_req_i = 1; wr_adr_i = 6'd9; wr_dat_i = 6'd3;
        wait_wr();
        wr_req_i = 0;
        repeat (4) tick();

        // Write adr 5 then read it back in the following cycle.
        wr_req_i = 1; wr_adr_i = 6'd5; wr_dat_i = 6'h2A;
        wait_wr();
        wr_req_i = 0; rd_req_i = 1; rd_adr_i = 6'd5;
        wait_rd();
        rd_req_i = 0;
        repeat (6) tick();

        // Sustained conflict: grants alternate starting with write.
        wr_req_i = 1; wr_adr_i = 6'd10; wr_dat_i = 6'd11;
        rd_req_i = 1; rd_adr_i = 6'd9;
        repeat (8) begin
            tick();
            if (got_wr) begin wr_adr_i = AW'($urandom); wr_dat_i = DW'($urandom); end
            if (got_rd) rd_adr_i = AW'($urandom);
        end
        wr_req_i = 0; rd_req_i = 0;
        repeat (6) tick();

        // Lone reader, addresses 0..3 back-to-back.
        for (int i = 0; i < 4; i++) begin
            rd_req_i = 1; rd_adr_i = AW'(i);
            tick();
        end
        rd_req_i = 0;
        repeat (6) tick();

        // Read granted, then clear starts the next cycle.
        rd_req_i = 1; rd_adr_i = 6'd5;
        wait_rd();
        rd_req_i = 0; clr_start_i = 1;
        tick(); clr_start_i = 0;
        repeat (80) tick();

        run_random(1500);

        // Reset while the clear counter is at 30.
        pulse_clear();
        begin
            int k = 0;
            while (m_cnt != 30 && k < 200) begin tick(); k++; end
            chk("clr_cnt_reach", m_cnt, 30);
        end
        @(posedge clk); #2;
        do_reset();
        repeat (80) tick();
        pulse_clear();
        repeat (80) tick();

        run_random(1500);
        repeat (10) tick();
        chk("reads_outstanding", q_due.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posi_md_ram_arb.md
POSI_MD_RAM_ARB -- requirements
Module: posi_md_ram_arb

Interface
REQ-001 Parameter ADR_WD, default 6, RAM address width (64 entries).
REQ-002 Parameter DAT_WD, default 6, RAM data width.
REQ-003 Parameter CLR_VAL, default 0, value written to every entry during clear.
REQ-004 Port list (the only fixed decision): one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr_start_i  input  1  one-cycle pulse that starts the clear sequence.
- clr_done_o  output  1  one-cycle pulse when the clear sequence completes.
- busy_o  output  1  high while the clear sequence is running.
- wr_req_i  input  1  write request (level).
- wr_adr_i  input  ADR_WD  write address.
- wr_dat_i  input  DAT_WD  write data.
- wr_ack_o  output  1  write granted this cycle (combinational).
- rd_req_i  input  1  read request (level).
- rd_adr_i  input  ADR_WD  read address.
- rd_ack_o  output  1  read granted this cycle (combinational).
- rd_vld_o  output  1  one-cycle pulse: rd_dat_o holds new read data.
- rd_dat_o  output  DAT_WD  registered read data; holds last value.
- ram_adr_o  output  ADR_WD  RAM address (registered).
- ram_wr_ena_o  output  1  RAM write enable, low active (registered).
- ram_wr_dat_o  output  DAT_WD  RAM write data (registered).
- ram_rd_ena_o  output  1  RAM read enable, low active (registered).
- ram_rd_dat_i  input  DAT_WD  RAM read data, valid the cycle after the RAM samples a read.

Function
REQ-005 State machine: IDLE, CLR. Reset enters IDLE.
REQ-006 IDLE -> CLR when clr_start_i=1; clear counter loads 0.
REQ-007 In CLR: one RAM write per cycle, address = counter, data = CLR_VAL; counter +1 per cycle.
REQ-008 CLR -> IDLE after address 2^ADR_WD-1 is issued; clr_done_o pulses the cycle after that last RAM write is driven onto ram_* outputs.
REQ-009 clr_start_i during CLR is ignored (no restart, no counter change).
REQ-010 busy_o=1 exactly while state=CLR; wr_ack_o=rd_ack_o=0 in CLR regardless of requests.
REQ-011 In IDLE, at most one of wr_ack_o/rd_ack_o is high per cycle; ack never asserted without its req.
REQ-012 Only one requester: it is acked in the same cycle.
REQ-013 Both request: round-robin; a 1-bit last_winner flag records the winner of the last conflict; the other requester wins; flag resets to "read" so the first conflict goes to write.
REQ-014 Non-conflict grants do not update last_winner.
REQ-015 Requester holds req/adr/dat stable until acked; a granted op is consumed in the ack cycle.
REQ-016 Ack in cycle T -> ram_adr_o/ram_wr_dat_o/enables driven in cycle T+1; write: ram_wr_ena_o=0, ram_rd_ena_o=1; read: ram_rd_ena_o=0, ram_wr_ena_o=1.
REQ-017 Cycle with no grant and no clear: ram_wr_ena_o=ram_rd_ena_o=1; ram_adr_o/ram_wr_dat_o hold previous values.
REQ-018 Read acked in T: ram_rd_dat_i captured into rd_dat_o at end of T+2; rd_vld_o=1 in T+3 for one cycle; back-to-back reads yield back-to-back rd_vld_o pulses.
REQ-019 Clear started in the cycle after a read ack still delivers that read's rd_vld_o/rd_dat_o.
REQ-020 Address arithmetic is unsigned ADR_WD-bit; clear counter covers exactly 2^ADR_WD entries.

Reset
REQ-021 rstn=0 asynchronously: state=IDLE, counter=0, last_winner=read, ram_wr_ena_o=1, ram_rd_ena_o=1, ram_adr_o=0, ram_wr_dat_o=0, rd_dat_o=0, rd_vld_o=0, clr_done_o=0, busy_o=0.
REQ-022 Reset mid-clear aborts the sequence; no clr_done_o; no in-flight rd_vld_o after release.
REQ-023 No RAM enable goes low in the first cycle after reset release unless a request/clear is accepted in that cycle.

Verification
REQ-024 Clear: clr_start_i pulse in cycle 0 -> busy_o=1 cycles 1..64; ram_wr_ena_o=0 with adr 0..63, dat 0 in cycles 2..65; clr_done_o=1 in cycle 66; rd/wr acks 0 throughout.
REQ-025 Write-then-read: write adr 5 dat 0x2A acked cycle T; read adr 5 acked T+1 -> rd_vld_o in T+4 with rd_dat_o=0x2A.
REQ-026 Conflict: wr_req_i and rd_req_i both held -> acks alternate W,R,W,R; exactly one per cycle.
REQ-027 Single requester: rd_req_i held alone 4 cycles, adr 0..3 -> rd_ack_o every cycle, 4 consecutive rd_vld_o pulses in order.
REQ-028 Reset mid-clear: rstn=0 at counter 30 -> all outputs at reset values immediately; after release clr_done_o stays 0 and a new clr_start_i restarts at address 0.
REQ-029 Requests during clear: wr_req_i held through CLR -> no ack until the cycle after clr_done_o would allow IDLE, then acked in first IDLE cycle.
